// File: rtl/nios2_mult_pipe_cell.sv
// nios2_mult_pipe_cell: three-stage pipelined multiplier for the Nios II MUL/MULX* family.
// Define NIOS2_MULT_PIPE_CELL_HIGH_EN to support the high-half ops (MULXSS/MULXSU/MULXUU).
module nios2_mult_pipe_cell #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  localparam int H  = DATA_W / 2;
  localparam int XW = DATA_W + H;

  logic              w_advance;
  logic              r_s1_valid;
  logic              r_s2_valid;
  logic              r_s3_valid;
  logic [DATA_W-1:0] r_s1_a;
  logic [DATA_W-1:0] r_s1_b;
  logic [TAG_W-1:0]  r_s1_tag;
  logic [TAG_W-1:0]  r_s2_tag;
  logic [DATA_W-1:0] r_s2_ll;
  logic [DATA_W-1:0] w_pp_ll;
  logic [DATA_W-1:0] w_result;
  logic [DATA_W-1:0] r_out_result;
  logic [TAG_W-1:0]  r_out_tag;

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign w_advance  = ~r_s3_valid | out_ready;
  assign in_ready   = w_advance;
  assign out_valid  = r_s3_valid;
  assign out_result = r_out_result;
  assign out_tag    = r_out_tag;
  assign busy       = r_s1_valid | r_s2_valid | r_s3_valid;

  assign w_pp_ll = {{H{1'b0}}, r_s1_a[H-1:0]} * {{H{1'b0}}, r_s1_b[H-1:0]};

`ifdef NIOS2_MULT_PIPE_CELL_HIGH_EN
  logic [1:0]          r_s1_op;
  logic [1:0]          r_s2_op;
  logic                w_a_sx;
  logic                w_b_sx;
  logic [XW-1:0]       w_pp_lh;
  logic [XW-1:0]       w_pp_hl;
  logic [XW-1:0]       r_s2_lh;
  logic [XW-1:0]       r_s2_hl;
  logic [DATA_W-1:0]   w_pp_hh;
  logic [DATA_W-1:0]   r_s2_hh;
  logic [2*DATA_W-1:0] w_prod;

  // High halves carry the operand sign; low halves are always unsigned.
  assign w_a_sx = ((r_s1_op == 2'b01) | (r_s1_op == 2'b10)) & r_s1_a[DATA_W-1];
  assign w_b_sx = (r_s1_op == 2'b01) & r_s1_b[DATA_W-1];

  assign w_pp_lh = {{DATA_W{1'b0}}, r_s1_a[H-1:0]} * {{DATA_W{w_b_sx}}, r_s1_b[DATA_W-1:H]};
  assign w_pp_hl = {{DATA_W{w_a_sx}}, r_s1_a[DATA_W-1:H]} * {{DATA_W{1'b0}}, r_s1_b[H-1:0]};
  assign w_pp_hh = {{H{w_a_sx}}, r_s1_a[DATA_W-1:H]} * {{H{w_b_sx}}, r_s1_b[DATA_W-1:H]};

  assign w_prod = {r_s2_hh, {DATA_W{1'b0}}}
                + {r_s2_lh, {H{1'b0}}}
                + {r_s2_hl, {H{1'b0}}}
                + {{DATA_W{1'b0}}, r_s2_ll};

  assign w_result = (r_s2_op == 2'b00) ? w_prod[DATA_W-1:0] : w_prod[2*DATA_W-1:DATA_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_op <= 2'b00;
      r_s2_op <= 2'b00;
      r_s2_lh <= '0;
      r_s2_hl <= '0;
      r_s2_hh <= '0;
    end else if (w_advance) begin
      if (in_valid) begin
        r_s1_op <= in_op;
      end
      if (r_s1_valid) begin
        r_s2_op <= r_s1_op;
        r_s2_lh <= w_pp_lh;
        r_s2_hl <= w_pp_hl;
        r_s2_hh <= w_pp_hh;
      end
    end
  end
`else
  logic [H-1:0] w_pp_lh;
  logic [H-1:0] w_pp_hl;
  logic [H-1:0] r_s2_lh;
  logic [H-1:0] r_s2_hl;
  logic         w_unused_op;

  // Only the low product half is produced, so the cross terms need just H bits.
  assign w_unused_op = ^in_op;
  assign w_pp_lh     = r_s1_a[H-1:0] * r_s1_b[DATA_W-1:H];
  assign w_pp_hl     = r_s1_a[DATA_W-1:H] * r_s1_b[H-1:0];
  assign w_result    = r_s2_ll + {r_s2_lh + r_s2_hl, {H{1'b0}}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_lh <= '0;
      r_s2_hl <= '0;
    end else if (w_advance && r_s1_valid) begin
      r_s2_lh <= w_pp_lh;
      r_s2_hl <= w_pp_hl;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid   <= 1'b0;
      r_s2_valid   <= 1'b0;
      r_s3_valid   <= 1'b0;
      r_s1_a       <= '0;
      r_s1_b       <= '0;
      r_s1_tag     <= '0;
      r_s2_tag     <= '0;
      r_s2_ll      <= '0;
      r_out_result <= '0;
      r_out_tag    <= '0;
    end else if (w_advance) begin
      r_s1_valid <= in_valid;
      r_s2_valid <= r_s1_valid;
      r_s3_valid <= r_s2_valid;
      if (in_valid) begin
        r_s1_a   <= in_src1;
        r_s1_b   <= in_src2;
        r_s1_tag <= in_tag;
      end
      if (r_s1_valid) begin
        r_s2_tag <= r_s1_tag;
        r_s2_ll  <= w_pp_ll;
      end
      // Bubbles leave the last result on the output bus untouched.
      if (r_s2_valid) begin
        r_out_result <= w_result;
        r_out_tag    <= r_s2_tag;
      end
    end
  end

endmodule

// File: tb/tb_nios2_mult_pipe_cell.sv
// Self-checking bench for nios2_mult_pipe_cell (DATA_W=32, TAG_W=5), scoreboard based.
// Expected values follow NIOS2_MULT_PIPE_CELL_HIGH_EN when it is defined for the build.
module tb_nios2_mult_pipe_cell;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_res_q[$];
  logic [4:0]  exp_tag_q[$];
  logic [31:0] sb_res;
  logic [4:0]  sb_tag;

  localparam logic [1:0]  OPS_OP [4] = '{2'b01, 2'b11, 2'b10, 2'b11};
  localparam logic [31:0] OPS_A  [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h8000_0000};
  localparam logic [31:0] OPS_B  [4] = '{32'h0000_0003, 32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0002};
  localparam logic [31:0] OPS_HI [4] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001};
  localparam logic [31:0] OPS_LO [4] = '{32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'h0000_0001, 32'h0000_0000};

  nios2_mult_pipe_cell #(.DATA_W(32), .TAG_W(5)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [1:0]  eff_op;
    logic [63:0] ax;
    logic [63:0] bx;
    logic [63:0] p;
    eff_op = op;
`ifndef NIOS2_MULT_PIPE_CELL_HIGH_EN
    eff_op = 2'b00;
`endif
    ax = (eff_op == 2'b01 || eff_op == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
    bx = (eff_op == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ax * bx;
    return (eff_op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Scoreboard: push on accepted input, pop and compare on output handshake.
  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        failures++;
        $display("FAIL in_ready_rule: got %b required %b", in_ready, (!out_valid || out_ready));
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_res_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: got result %h tag %0d, required no output", out_result, out_tag);
        end else begin
          sb_res = exp_res_q.pop_front();
          sb_tag = exp_tag_q.pop_front();
          if (out_result !== sb_res || out_tag !== sb_tag) begin
            failures++;
            $display("FAIL sb_result: got %h tag %0d required %h tag %0d", out_result, out_tag, sb_res, sb_tag);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_res_q.push_back(model(in_op, in_src1, in_src2));
        exp_tag_q.push_back(in_tag);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_src1  = a;
    in_src2  = b;
    in_tag   = tag;
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (busy && n < 20) begin
      cyc();
      n++;
    end
    checks++;
    if (busy !== 1'b0 || exp_res_q.size() != 0) begin
      failures++;
      $display("FAIL drain: busy %b pending %0d, required busy 0 pending 0", busy, exp_res_q.size());
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_src1   = '0;
    in_src2   = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    #12;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ctrl: got valid %b busy %b ready %b required 0 0 1", out_valid, busy, in_ready);
    end
    checks++;
    if (out_result !== 32'h0 || out_tag !== 5'h0) begin
      failures++;
      $display("FAIL reset_data: got %h tag %0d required 0 tag 0", out_result, out_tag);
    end
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic test_latency();
    int n;
    drive_op(2'b00, 32'h0001_0003, 32'h0002_0005, 5'd7);
    cyc();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      cyc();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || n != 3) begin
      failures++;
      $display("FAIL latency: got %0d edges (valid %b) required 3", n, out_valid);
    end
    checks++;
    if (out_result !== 32'h000B_000F || out_tag !== 5'd7) begin
      failures++;
      $display("FAIL mul_basic: got %h tag %0d required 000b000f tag 7", out_result, out_tag);
    end
    cyc();
  endtask

  task automatic test_ops();
    int n;
    logic [31:0] req;
    for (int k = 0; k < 4; k++) begin
`ifdef NIOS2_MULT_PIPE_CELL_HIGH_EN
      req = OPS_HI[k];
`else
      req = OPS_LO[k];
`endif
      drive_op(OPS_OP[k], OPS_A[k], OPS_B[k], 5'(k + 1));
      cyc();
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 10) begin
        cyc();
        n++;
      end
      checks++;
      if (out_valid !== 1'b1 || out_result !== req || n != 3) begin
        failures++;
        $display("FAIL op_case%0d: got %h valid %b after %0d edges required %h after 3", k, out_result, out_valid, n, req);
      end
      cyc();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vmask;
    logic [4:0]  seen[10];
    int          ntag;
    int          rdy_bad;
    vmask   = '0;
    ntag    = 0;
    rdy_bad = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i < 10) begin
        drive_op(2'($urandom_range(0, 3)), rnd_operand(), rnd_operand(), 5'(i));
        if (in_ready !== 1'b1) rdy_bad++;
      end else begin
        in_valid = 1'b0;
      end
      cyc();
      vmask[i] = out_valid;
      if (out_valid && ntag < 10) begin
        seen[ntag] = out_tag;
        ntag++;
      end
    end
    checks++;
    if (rdy_bad != 0) begin
      failures++;
      $display("FAIL b2b_ready: got %0d cycles not ready required 0", rdy_bad);
    end
    checks++;
    if (vmask !== 16'h0FFC) begin
      failures++;
      $display("FAIL b2b_valid_mask: got %h required 0ffc", vmask);
    end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (k >= ntag || seen[k] !== 5'(k)) begin
        failures++;
        $display("FAIL b2b_tag%0d: got %0d (seen %0d) required %0d", k, seen[k], ntag, k);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] hold_res;
    logic [4:0]  hold_tag;
    int          bad;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_op(2'($urandom_range(0, 3)), rnd_operand(), rnd_operand(), 5'(16 + i));
      cyc();
    end
    drive_op(2'b11, 32'hDEAD_BEEF, 32'h1234_5678, 5'd19);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL stall_full: got valid %b ready %b busy %b required 1 0 1", out_valid, in_ready, busy);
    end
    hold_res = out_result;
    hold_tag = out_tag;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== hold_res || out_tag !== hold_tag) bad++;
    end
    checks++;
    if (bad != 0 || hold_tag !== 5'd16) begin
      failures++;
      $display("FAIL stall_hold: got %0d unstable cycles head tag %0d required 0 and tag 16", bad, hold_tag);
    end
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_op(2'($urandom_range(0, 3)), rnd_operand(), rnd_operand(), 5'(24 + i));
      cyc();
    end
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid: got valid %b busy %b ready %b result %h required 0 0 1 0",
               out_valid, busy, in_ready, out_result);
    end
    exp_res_q.delete();
    exp_tag_q.delete();
    cyc();
    cyc();
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (out_valid || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_ghost: got %0d cycles with activity required 0", seen);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0)
        drive_op(2'($urandom_range(0, 3)), rnd_operand(), rnd_operand(), 5'($urandom_range(0, 31)));
      else
        in_valid = 1'b0;
      out_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_latency();
    test_ops();
    test_back_to_back();
    test_stall();
    drain();
    test_reset_mid();
    test_random();
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
